bfp_block_encoder: RTL and testbench

//  Streaming block-floating-point encoder (quantiser). Takes BLOCK_SIZE signed fixed-point samples per block
//  and finds the shared exponent from the largest magnitude in the block. It then emits one packed BFP element
//  per sample: {sign, shared exponent, mantissa}. Sits upstream of dot_product_top and produces its v1/v2 element streams.

---
 rtl/bfp_pkg.sv | 27 ++
 rtl/bfp_leading_one.sv | 21 ++
 rtl/bfp_block_encoder.sv | 154 +++++++++++++++
 tb/tb_bfp_block_encoder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bfp_pkg.sv
// Shared definitions for the block-floating-point encoder and its consumers.
// Packed element layout (MSB..LSB): {sign, biased exponent, mantissa 0.m}.
package bfp_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CALC    = 2'd1,
        EMIT    = 2'd2
    } bfp_state_e;

    // Default configuration
    localparam int DEF_IN_WIDTH   = 16;
    localparam int DEF_FRAC_BITS  = 8;
    localparam int DEF_BLOCK_SIZE = 4;
    localparam int DEF_MAN_W      = 10;
    localparam int DEF_EXP_W      = 5;
    localparam int DEF_EXP_BIAS   = 15;

    localparam int ELEM_W = 1 + DEF_EXP_W + DEF_MAN_W;
    localparam int CNT_W  = $clog2(DEF_BLOCK_SIZE);

    // Field offsets inside a packed element (default configuration)
    localparam int MAN_LSB  = 0;
    localparam int EXP_LSB  = DEF_MAN_W;
    localparam int SIGN_BIT = DEF_MAN_W + DEF_EXP_W;

endpackage

// File: rtl/bfp_leading_one.sv
// Combinational priority encoder: index of the most significant set bit.
// idx_o is 0 and zero_o is 1 when the input is all zeros.
module bfp_leading_one #(
    parameter int W  = 16,
    parameter int IW = $clog2(W)
) (
    input  logic [W-1:0]  in_i,
    output logic [IW-1:0] idx_o,
    output logic          zero_o
);

    // Scan upward so the highest set bit wins
    always_comb begin
        idx_o  = '0;
        zero_o = ~|in_i;
        for (int i = 0; i < W; i++) begin
            if (in_i[i]) idx_o = IW'(i);
        end
    end

endmodule

// File: rtl/bfp_block_encoder.sv
// Streaming block-floating-point encoder: gathers BLOCK_SIZE samples, derives
// the shared exponent from the OR of all magnitudes, then emits one packed
// {sign, exponent, mantissa} element per sample.
// Optional build macro: BFP_ROUND_NEAREST_EN selects round-half-up with
// saturation on right shifts; otherwise shifted-out bits are truncated.
module bfp_block_encoder
    import bfp_pkg::*;
#(
    parameter int IN_WIDTH   = DEF_IN_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int MAN_W      = DEF_MAN_W,
    parameter int EXP_W      = DEF_EXP_W,
    parameter int EXP_BIAS   = DEF_EXP_BIAS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_WIDTH-1:0]      in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_data,
    output logic                     out_last
);

    localparam int CW   = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam int PW   = $clog2(IN_WIDTH);
    localparam int SH_W = $clog2(IN_WIDTH + MAN_W) + 2;
    localparam int WW   = IN_WIDTH + MAN_W + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(BLOCK_SIZE - 1);
    localparam int EXP_MAX = (1 << EXP_W) - 1;

    bfp_state_e              state_q, state_d;
    logic [CW-1:0]           cnt_q;
    logic [IN_WIDTH-1:0]     acc_q;
    logic [IN_WIDTH:0]       buf_q [BLOCK_SIZE];   // {sign, magnitude}
    logic [EXP_W-1:0]        exp_q, exp_d;
    logic signed [SH_W-1:0]  shift_q, shift_d;
    logic                    live_q;

    logic                    in_acc, out_hs;
    logic [IN_WIDTH-1:0]     in_mag;
    logic [PW-1:0]           lo_idx;
    logic                    lo_zero;
    int                      e_int, s_int;
    logic [IN_WIDTH:0]       cur;
    logic [SH_W-1:0]         sh_pos, sh_neg;
    logic [WW-1:0]           wide;
    logic [MAN_W-1:0]        man;

    // live_q keeps in_ready low for the first cycle out of reset
    assign in_ready  = live_q && (state_q == COLLECT);
    assign out_valid = (state_q == EMIT);
    assign out_last  = out_valid && (cnt_q == LAST_IDX);
    assign in_acc    = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude
    assign in_mag    = in_data[IN_WIDTH-1] ? -in_data : in_data;

    bfp_leading_one #(.W(IN_WIDTH), .IW(PW)) u_lo (
        .in_i   (acc_q),
        .idx_o  (lo_idx),
        .zero_o (lo_zero)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= COLLECT;
        else        state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (in_acc && cnt_q == LAST_IDX) state_d = CALC;
            CALC:    state_d = EMIT;
            EMIT:    if (out_hs && cnt_q == LAST_IDX) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // Shared exponent (clamped) and mantissa alignment shift (unclamped)
    always_comb begin
        e_int   = int'(lo_idx) + 1 - FRAC_BITS + EXP_BIAS;
        s_int   = int'(lo_idx) + 1 - MAN_W;
        exp_d   = '0;
        shift_d = '0;
        if (!lo_zero) begin
            if (e_int < 0)            exp_d = '0;
            else if (e_int > EXP_MAX) exp_d = EXP_W'(EXP_MAX);
            else                      exp_d = EXP_W'(e_int);
            shift_d = SH_W'(s_int);
        end
    end

    // Counter, accumulator and per-block exponent/shift registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q  <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            exp_q   <= '0;
            shift_q <= '0;
        end else begin
            live_q <= 1'b1;
            if (in_acc || out_hs)
                cnt_q <= (cnt_q == LAST_IDX) ? '0 : cnt_q + CW'(1);
            if (in_acc)
                acc_q <= acc_q | in_mag;
            if (state_q == CALC) begin
                exp_q   <= exp_d;
                shift_q <= shift_d;
                acc_q   <= '0;
            end
        end
    end

    // Sample buffer; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (in_acc) buf_q[cnt_q] <= {in_data[IN_WIDTH-1], in_mag};
    end

    // Align the current magnitude into the mantissa field; a zero sample
    // keeps the shared exponent with a zero mantissa
    always_comb begin
        cur    = buf_q[cnt_q];
        sh_pos = $unsigned(shift_q);
        sh_neg = $unsigned(-shift_q);
        wide   = '0;
        if (shift_q < 0) begin
            wide = WW'(cur[IN_WIDTH-1:0]) << sh_neg;
        end else begin
`ifdef BFP_ROUND_NEAREST_EN
            if (shift_q != 0)
                wide = (WW'(cur[IN_WIDTH-1:0]) + (WW'(1) << (sh_pos - SH_W'(1)))) >> sh_pos;
            else
                wide = WW'(cur[IN_WIDTH-1:0]);
`else
            wide = WW'(cur[IN_WIDTH-1:0]) >> sh_pos;
`endif
        end
        // Rounding can carry into 2^MAN_W; saturate instead of bumping the exponent
        man = (wide > WW'((1 << MAN_W) - 1)) ? '1 : wide[MAN_W-1:0];
    end

    // Output element, forced to zero when not presenting
    always_comb begin
        out_data = '0;
        if (out_valid) out_data = {cur[IN_WIDTH], exp_q, man};
    end

endmodule

// File: tb/tb_bfp_block_encoder.sv
// Scoreboard bench for bfp_block_encoder: stimulus pushes expected elements,
// a negedge monitor pops and compares on every output handshake.
module tb_bfp_block_encoder;
    import bfp_pkg::*;

    typedef struct packed {
        logic [ELEM_W-1:0] d;
        logic              l;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [15:0]       in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [ELEM_W-1:0] out_data;
    logic              out_last;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   tmo_cnt = 0;
    int   tmo_seen = 0;
    int   rst_age = 0;
    bit   done_req = 1'b0;
    bit   done_seen = 1'b0;
    bit   hold_v = 1'b0;
    logic [ELEM_W-1:0] hold_d;
    logic              hold_l;
    exp_t e;

    logic [15:0] B_IN [4] = '{16'h0380, 16'h0100, 16'hFE00, 16'h0040};
    logic [15:0] B_EX [4] = '{16'h4780, 16'h4500, 16'hC600, 16'h4440};
    logic [15:0] R_IN [4] = '{16'h7FFF, 16'h001F, 16'h0000, 16'h0000};
`ifdef BFP_ROUND_NEAREST_EN
    logic [15:0] R_EX [4] = '{16'h5BFF, 16'h5801, 16'h5800, 16'h5800};
`else
    logic [15:0] R_EX [4] = '{16'h5BFF, 16'h5800, 16'h5800, 16'h5800};
`endif
    logic [15:0] Z_IN [4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic [15:0] Z_EX [4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    // -2^15 as largest magnitude: p=15, exp=23, shift=6
    logic [15:0] N_IN [4] = '{16'h8000, 16'h0040, 16'hFFC0, 16'h0001};
    logic [15:0] N_EX [4] = '{16'hDE00, 16'h5C01, 16'hDC01, 16'h5C00};
    // Small block: p=1, exp=9, shift=-8 (left shift, exact)
    logic [15:0] S_IN [4] = '{16'h0003, 16'h0001, 16'h0000, 16'h0000};
    logic [15:0] S_EX [4] = '{16'h2700, 16'h2500, 16'h2400, 16'h2400};

    always #5 clk = ~clk;

    bfp_block_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    // Monitor: owns all comparison counting
    always @(negedge clk) begin
        if (!rst_n) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL reset_state got rdy=%b vld=%b data=%h last=%b want 0/0/0000/0",
                         in_ready, out_valid, out_data, out_last);
            end
            rst_age = 0;
            hold_v  = 1'b0;
        end else begin
            if (rst_age < 3) rst_age++;
            if (rst_age == 2) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL ready_after_reset got %b want 1", in_ready);
                end
            end
            if (hold_v) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== hold_d || out_last !== hold_l) begin
                    errors++;
                    $display("FAIL stall_hold got vld=%b data=%h last=%b want 1/%h/%b",
                             out_valid, out_data, out_last, hold_d, hold_l);
                end
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            hold_l = out_last;
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_in_emit got %b want 0", in_ready);
                end
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL stray_elem got data=%h last=%b want none", out_data, out_last);
                end else begin
                    e = sbq.pop_front();
                    if (out_data !== e.d || out_last !== e.l) begin
                        errors++;
                        $display("FAIL elem got data=%h last=%b want data=%h last=%b",
                                 out_data, out_last, e.d, e.l);
                    end
                end
            end
        end
        if (tmo_cnt != tmo_seen) begin
            checks++;
            errors++;
            $display("FAIL timeout got %0d expired waits want 0", tmo_cnt - tmo_seen);
            tmo_seen = tmo_cnt;
        end
        if (done_req && !done_seen) begin
            done_seen = 1'b1;
            checks++;
            if (sbq.size() != 0) begin
                errors++;
                $display("FAIL leftover got %0d pending want 0", sbq.size());
            end
        end
    end

    task automatic push_exp(input logic [15:0] ex [4]);
        for (int i = 0; i < 4; i++) sbq.push_back(exp_t'({ex[i], (i == 3)}));
    endtask

    // Present one sample and hold it until accepted
    task automatic send_sample(input logic [15:0] x);
        int n;
        in_data  = x;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) tmo_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input logic [15:0] s [4], input bit keep_valid);
        for (int i = 0; i < 4; i++) send_sample(s[i]);
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || out_valid) && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (n >= 300) tmo_cnt++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        push_exp(B_EX); send_block(B_IN, 1'b0); wait_drain();
        push_exp(R_EX); send_block(R_IN, 1'b0); wait_drain();
        push_exp(Z_EX); send_block(Z_IN, 1'b0); wait_drain();
        push_exp(N_EX); send_block(N_IN, 1'b0); wait_drain();
        push_exp(S_EX); send_block(S_IN, 1'b0); wait_drain();

        // Backpressure: stall for 3 cycles after the first element
        push_exp(B_EX);
        send_block(B_IN, 1'b0);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) tmo_cnt++;
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drain();

        // Partial block discarded by reset
        send_sample(16'h7000);
        send_sample(16'h1234);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_exp(B_EX); send_block(B_IN, 1'b0); wait_drain();

        // Back-to-back blocks with in_valid held high
        push_exp(B_EX);
        push_exp(R_EX);
        send_block(B_IN, 1'b1);
        send_block(R_IN, 1'b0);
        wait_drain();

        done_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
